// File: rtl/test_ostream_checker_if.sv
// Stream bundle between a test bench and the output-stream checker.
//   exp_msg/exp_val/exp_rdy : expected-message enqueue port
//   msg/val/rdy             : DUT message stream into the checker
// master = the side producing both streams, slave = the checker.
interface test_ostream_checker_if #(
   parameter int unsigned p_msg_nbits = 32
) ();
   logic [p_msg_nbits-1:0] exp_msg;
   logic                   exp_val;
   logic                   exp_rdy;
   logic [p_msg_nbits-1:0] msg;
   logic                   val;
   logic                   rdy;

   modport master (
      output exp_msg, exp_val, msg, val,
      input  exp_rdy, rdy
   );

   modport slave (
      input  exp_msg, exp_val, msg, val,
      output exp_rdy, rdy
   );
endinterface

// File: rtl/test_ostream_checker.sv
// Output-stream checker: holds expected messages in a FIFO, receives DUT
// messages under fixed or LFSR-random backpressure, compares them in order
// and keeps pass/fail counters plus first-mismatch capture.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   bus (slave)     : exp_msg/exp_val/exp_rdy enqueue, msg/val/rdy receive
//   delay_cfg, mode : idle-gap length (mode 0) or random-gap mask (mode 1)
//   num_recv/num_err/err/first_err_idx/first_err_msg : result reporting
//   pending         : expected entries still outstanding
module test_ostream_checker #(
   parameter int unsigned p_msg_nbits   = 32,
   parameter int unsigned p_depth       = 16,
   parameter int unsigned p_delay_nbits = 8,
   parameter logic [15:0] p_lfsr_seed   = 16'hACE1
) (
   input  logic                         clk,
   input  logic                         rst,
   test_ostream_checker_if.slave        bus,
   input  logic [p_delay_nbits-1:0]     delay_cfg,
   input  logic                         mode,
   output logic [31:0]                  num_recv,
   output logic [31:0]                  num_err,
   output logic                         err,
   output logic [31:0]                  first_err_idx,
   output logic [p_msg_nbits-1:0]       first_err_msg,
   output logic [$clog2(p_depth):0]     pending
);
   localparam int unsigned PtrW = $clog2(p_depth);
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned DW   = p_delay_nbits;

   typedef enum logic {ST_READY, ST_DELAY} state_e;

   state_e                 state_q, state_d;
   logic [DW-1:0]          cnt_q, cnt_d;
   logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]        pending_q, pending_d;
   logic [15:0]            lfsr_q, lfsr_d;
   logic [31:0]            num_recv_q, num_recv_d;
   logic [31:0]            num_err_q, num_err_d;
   logic                   err_q, err_d;
   logic [31:0]            first_err_idx_q, first_err_idx_d;
   logic [p_msg_nbits-1:0] first_err_msg_q, first_err_msg_d;
   logic [p_msg_nbits-1:0] mem_q [p_depth];

   logic          full;
   logic          rdy_c;
   logic          push;
   logic          pop;
   logic          mismatch;
   logic [DW-1:0] dly;
   logic [15:0]   lfsr_next;

   assign full        = (pending_q == CntW'(p_depth));
   assign rdy_c       = (state_q == ST_READY) && (pending_q != '0);
   assign bus.exp_rdy = !full;
   assign bus.rdy     = rdy_c;

   // A push while full is taken only together with a pop, reusing the slot
   // the pop frees at the same edge.
   assign pop      = bus.val && rdy_c;
   assign push     = bus.exp_val && (!full || pop);
   assign mismatch = (mem_q[rd_ptr_q] != bus.msg);

   // Galois LFSR, x^16+x^14+x^13+x^11+1
   assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
   assign dly       = mode ? (DW'(lfsr_q) & delay_cfg) : delay_cfg;

   // Next-state: FIFO pointers, receive/compare bookkeeping, gap FSM
   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      pending_d       = pending_q;
      lfsr_d          = lfsr_q;
      num_recv_d      = num_recv_q;
      num_err_d       = num_err_q;
      err_d           = err_q;
      first_err_idx_d = first_err_idx_q;
      first_err_msg_d = first_err_msg_q;

      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);

      case ({push, pop})
         2'b10:   pending_d = pending_q + CntW'(1);
         2'b01:   pending_d = pending_q - CntW'(1);
         default: pending_d = pending_q;
      endcase

      if (pop) begin
         rd_ptr_d   = rd_ptr_q + PtrW'(1);
         num_recv_d = num_recv_q + 32'd1;
         lfsr_d     = lfsr_next;
         if (mismatch) begin
            num_err_d = num_err_q + 32'd1;
            err_d     = 1'b1;
            if (!err_q) begin
               first_err_idx_d = num_recv_q;
               first_err_msg_d = bus.msg;
            end
         end
         if (dly == '0) begin
            state_d = ST_READY;
            cnt_d   = '0;
         end else begin
            state_d = ST_DELAY;
            cnt_d   = dly;
         end
      end else if (state_q == ST_DELAY) begin
         // cnt==0 only occurs straight out of reset; treat it like cnt==1
         if (cnt_q <= DW'(1)) begin
            state_d = ST_READY;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q - DW'(1);
         end
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= ST_DELAY;
         cnt_q           <= '0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         pending_q       <= '0;
         lfsr_q          <= p_lfsr_seed;
         num_recv_q      <= '0;
         num_err_q       <= '0;
         err_q           <= 1'b0;
         first_err_idx_q <= '0;
         first_err_msg_q <= '0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         pending_q       <= pending_d;
         lfsr_q          <= lfsr_d;
         num_recv_q      <= num_recv_d;
         num_err_q       <= num_err_d;
         err_q           <= err_d;
         first_err_idx_q <= first_err_idx_d;
         first_err_msg_q <= first_err_msg_d;
      end
   end

   // Expected-message storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.exp_msg;
   end

   assign num_recv      = num_recv_q;
   assign num_err       = num_err_q;
   assign err           = err_q;
   assign first_err_idx = first_err_idx_q;
   assign first_err_msg = first_err_msg_q;
   assign pending       = pending_q;
endmodule

// File: tb/tb_test_ostream_checker.sv
// Directed bench for test_ostream_checker (p_depth=4 so the full/wrap case
// is reachable with a short preload).
module tb_test_ostream_checker;
   localparam int unsigned MW = 32;
   localparam int unsigned DEPTH = 4;

   logic            clk;
   logic            rst;
   logic [7:0]      delay_cfg;
   logic            mode;
   logic [31:0]     num_recv;
   logic [31:0]     num_err;
   logic            err;
   logic [31:0]     first_err_idx;
   logic [MW-1:0]   first_err_msg;
   logic [2:0]      pending;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   test_ostream_checker_if #(.p_msg_nbits(MW)) bus ();

   test_ostream_checker #(
      .p_msg_nbits  (MW),
      .p_depth      (DEPTH),
      .p_delay_nbits(8),
      .p_lfsr_seed  (16'hACE1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .delay_cfg    (delay_cfg),
      .mode         (mode),
      .num_recv     (num_recv),
      .num_err      (num_err),
      .err          (err),
      .first_err_idx(first_err_idx),
      .first_err_msg(first_err_msg),
      .pending      (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // All driving tasks are entered and left at a negedge.
   task automatic do_reset();
      rst = 1'b0;
      bus.exp_val = 1'b0; bus.exp_msg = '0; bus.val = 1'b0; bus.msg = '0;
      mode = 1'b0; delay_cfg = 8'd0;
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic push(input logic [MW-1:0] v);
      bus.exp_val = 1'b1; bus.exp_msg = v;
      @(negedge clk);
      bus.exp_val = 1'b0;
   endtask

   // Returns the posedge index at which the transfer happens.
   task automatic send(input logic [MW-1:0] v, output int t);
      int n = 0;
      bus.val = 1'b1; bus.msg = v;
      while (bus.rdy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      checks++;
      if (n >= 50) begin errors++; $display("FAIL send_timeout: msg %0h never accepted", v); end
      t = cyc + 1;
      @(negedge clk);
      bus.val = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.exp_val = 1'b0; bus.val = 1'b0; mode = 1'b0; delay_cfg = 8'd0;
      bus.exp_msg = '0; bus.msg = '0;
      @(negedge clk);
      checks++; if (bus.rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %0b want 0", bus.rdy); end
      checks++; if (bus.exp_rdy !== 1'b1) begin errors++; $display("FAIL reset_exp_rdy: got %0b want 1", bus.exp_rdy); end
      checks++; if (pending !== 3'd0) begin errors++; $display("FAIL reset_pending: got %0d want 0", pending); end
      checks++; if (num_recv !== 32'd0 || num_err !== 32'd0 || err !== 1'b0 || first_err_idx !== 32'd0)
         begin errors++; $display("FAIL reset_counters: recv %0d err_cnt %0d err %0b idx %0d want all 0", num_recv, num_err, err, first_err_idx); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_back_to_back();
      int t0, t1, t2;
      do_reset();
      push(32'h11); push(32'h22); push(32'h33);
      send(32'h11, t0); send(32'h22, t1); send(32'h33, t2);
      checks++; if (t1 != t0 + 1 || t2 != t1 + 1) begin errors++; $display("FAIL b2b_timing: edges %0d %0d %0d want consecutive", t0, t1, t2); end
      checks++; if (num_recv !== 32'd3) begin errors++; $display("FAIL b2b_num_recv: got %0d want 3", num_recv); end
      checks++; if (num_err !== 32'd0 || err !== 1'b0) begin errors++; $display("FAIL b2b_err: num_err %0d err %0b want 0 0", num_err, err); end
      checks++; if (pending !== 3'd0) begin errors++; $display("FAIL b2b_pending: got %0d want 0", pending); end
   endtask

   task automatic test_fixed_delay();
      int t0, t1;
      do_reset();
      delay_cfg = 8'd2;
      push(32'h5A); push(32'h5B);
      checks++; if (bus.rdy !== 1'b1) begin errors++; $display("FAIL delay_rdy0: got %0b want 1", bus.rdy); end
      send(32'h5A, t0);
      checks++; if (bus.rdy !== 1'b0) begin errors++; $display("FAIL delay_rdy1: got %0b want 0", bus.rdy); end
      @(negedge clk);
      checks++; if (bus.rdy !== 1'b0) begin errors++; $display("FAIL delay_rdy2: got %0b want 0", bus.rdy); end
      @(negedge clk);
      checks++; if (bus.rdy !== 1'b1) begin errors++; $display("FAIL delay_rdy3: got %0b want 1", bus.rdy); end
      send(32'h5B, t1);
      checks++; if (t1 != t0 + 3) begin errors++; $display("FAIL delay_spacing: got %0d want 3", t1 - t0); end
   endtask

   task automatic test_mismatch();
      int t;
      do_reset();
      push(32'hA); push(32'hB); push(32'hC);
      send(32'hA, t); send(32'hF, t); send(32'hE, t);
      checks++; if (num_err !== 32'd2) begin errors++; $display("FAIL mm_num_err: got %0d want 2", num_err); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL mm_err: got %0b want 1", err); end
      checks++; if (first_err_idx !== 32'd1) begin errors++; $display("FAIL mm_first_idx: got %0d want 1", first_err_idx); end
      checks++; if (first_err_msg !== 32'hF) begin errors++; $display("FAIL mm_first_msg: got %0h want f", first_err_msg); end
      checks++; if (num_recv !== 32'd3) begin errors++; $display("FAIL mm_num_recv: got %0d want 3", num_recv); end
   endtask

   task automatic test_full_wrap();
      int t;
      logic [MW-1:0] exp_head;
      do_reset();
      for (int i = 0; i < 4; i++) push(MW'(32'h40 + i));
      checks++; if (pending !== 3'd4) begin errors++; $display("FAIL full_pending: got %0d want 4", pending); end
      checks++; if (bus.exp_rdy !== 1'b0) begin errors++; $display("FAIL full_exp_rdy: got %0b want 0", bus.exp_rdy); end
      push(32'h99);
      checks++; if (pending !== 3'd4) begin errors++; $display("FAIL full_ignore: pending %0d want 4", pending); end
      for (int i = 0; i < 10; i++) begin
         exp_head = (i < 4) ? MW'(32'h40 + i) : MW'(32'h50 + i - 4);
         bus.val = 1'b1; bus.msg = exp_head;
         bus.exp_val = 1'b1; bus.exp_msg = MW'(32'h50 + i);
         checks++; if (bus.rdy !== 1'b1) begin errors++; $display("FAIL wrap_rdy%0d: got %0b want 1", i, bus.rdy); end
         @(negedge clk);
         checks++; if (pending !== 3'd4) begin errors++; $display("FAIL wrap_pending%0d: got %0d want 4", i, pending); end
      end
      bus.val = 1'b0; bus.exp_val = 1'b0;
      for (int i = 6; i < 10; i++) send(MW'(32'h50 + i), t);
      checks++; if (num_recv !== 32'd14) begin errors++; $display("FAIL wrap_num_recv: got %0d want 14", num_recv); end
      checks++; if (num_err !== 32'd0) begin errors++; $display("FAIL wrap_num_err: got %0d want 0", num_err); end
      checks++; if (pending !== 3'd0) begin errors++; $display("FAIL wrap_drain: pending %0d want 0", pending); end
   endtask

   // Six transfers under random gaps; returns the five idle gaps.
   task automatic run_lfsr(output int g [5]);
      int tt [6];
      do_reset();
      mode = 1'b1; delay_cfg = 8'h03;
      for (int i = 0; i < 4; i++) push(MW'(32'h60 + i));
      fork
         begin
            for (int i = 4; i < 6; i++) begin
               int n = 0;
               while (bus.exp_rdy !== 1'b1 && n < 100) begin @(negedge clk); n++; end
               push(MW'(32'h60 + i));
            end
         end
         begin
            for (int i = 0; i < 6; i++) send(MW'(32'h60 + i), tt[i]);
         end
      join
      for (int i = 0; i < 5; i++) g[i] = tt[i+1] - tt[i] - 1;
   endtask

   task automatic test_lfsr();
      int g1 [5];
      int g2 [5];
      int exp_g [5] = '{1, 0, 0, 0, 2};
      run_lfsr(g1);
      for (int i = 0; i < 5; i++) begin
         checks++; if (g1[i] != exp_g[i]) begin errors++; $display("FAIL lfsr_gap%0d: got %0d want %0d", i, g1[i], exp_g[i]); end
      end
      checks++; if (num_err !== 32'd0) begin errors++; $display("FAIL lfsr_num_err: got %0d want 0", num_err); end
      run_lfsr(g2);
      for (int i = 0; i < 5; i++) begin
         checks++; if (g2[i] != exp_g[i]) begin errors++; $display("FAIL lfsr_rerun%0d: got %0d want %0d", i, g2[i], exp_g[i]); end
      end
   endtask

   task automatic test_async_reset();
      int t;
      do_reset();
      delay_cfg = 8'd5;
      push(32'h31); push(32'h32);
      send(32'h31, t);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      checks++; if (bus.rdy !== 1'b0) begin errors++; $display("FAIL arst_rdy: got %0b want 0", bus.rdy); end
      checks++; if (num_recv !== 32'd0) begin errors++; $display("FAIL arst_num_recv: got %0d want 0", num_recv); end
      checks++; if (pending !== 3'd0 || bus.exp_rdy !== 1'b1) begin errors++; $display("FAIL arst_fifo: pending %0d exp_rdy %0b want 0 1", pending, bus.exp_rdy); end
      @(negedge clk);
      rst = 1'b1; delay_cfg = 8'd0;
      push(32'h77);
      send(32'h77, t);
      checks++; if (num_recv !== 32'd1 || num_err !== 32'd0) begin errors++; $display("FAIL arst_after: recv %0d err %0d want 1 0", num_recv, num_err); end
   endtask

   initial begin
      rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_back_to_back();
      test_fixed_delay();
      test_mismatch();
      test_full_wrap();
      test_lfsr();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
